// File: rtl/calc_if.sv
// Operator-input and display bundle between the input manager, calc_engine and the display manager.
// CALC_MEM_EN adds the mem_store / mem_recall pulses.
interface calc_if #(
    parameter int DIGITS = 3
);
    logic                  digit_valid;
    logic [3:0]            digit;
    logic                  op_valid;
    logic [1:0]            op;
    logic                  neg_toggle;
    logic                  equal_valid;
    logic                  clear;
`ifdef CALC_MEM_EN
    logic                  mem_store;
    logic                  mem_recall;
`endif
    logic [8*DIGITS-1:0]   disp_bcd;
    logic                  disp_neg;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [2:0]            state;

    modport master (
`ifdef CALC_MEM_EN
        output mem_store, mem_recall,
`endif
        output digit_valid, digit, op_valid, op, neg_toggle, equal_valid, clear,
        input  disp_bcd, disp_neg, busy, done, error, state
    );

    modport slave (
`ifdef CALC_MEM_EN
        input  mem_store, mem_recall,
`endif
        input  digit_valid, digit, op_valid, op, neg_toggle, equal_valid, clear,
        output disp_bcd, disp_neg, busy, done, error, state
    );
endinterface

// File: rtl/calc_engine.sv
// Calculator core: operand entry, sequential signed ALU and double-dabble result conversion.
// Optional result memory (mem_store / mem_recall) enabled by defining CALC_MEM_EN.
module calc_engine #(
    parameter int DIGITS = 3
) (
    input  logic   clk,
    input  logic   reset_n,
    calc_if.slave  bus
);
    localparam int OPW  = $clog2(10**DIGITS);
    localparam int MAGW = 2*OPW;
    localparam int BCDW = 8*DIGITS;
    localparam int ENTW = 4*DIGITS;
    localparam int CNTW = $clog2(MAGW+1);
    localparam int ECW  = $clog2(DIGITS+1);
    localparam logic [MAGW-1:0] MAXV = MAGW'(10**DIGITS - 1);

    typedef enum logic [2:0] {
        S_ENTER_A = 3'd0,
        S_ENTER_B = 3'd1,
        S_CALC    = 3'd2,
        S_CONVERT = 3'd3,
        S_SHOW    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t            r_state;
    logic [1:0]        r_op;
    logic [OPW-1:0]    r_ent_mag;
    logic [ENTW-1:0]   r_ent_bcd;
    logic              r_ent_neg;
    logic [ECW-1:0]    r_ent_cnt;
    logic [OPW-1:0]    r_a_mag;
    logic              r_a_neg;
    logic [OPW-1:0]    r_b_mag;
    logic              r_b_neg;
    logic [CNTW-1:0]   r_cnt;
    logic [MAGW-1:0]   r_mcand;
    logic [OPW-1:0]    r_mplier;
    logic [MAGW-1:0]   r_acc;
    logic [OPW:0]      r_rem;
    logic [OPW-1:0]    r_quo;
    logic [MAGW-1:0]   r_bin;
    logic [BCDW-1:0]   r_bcd;
    logic [MAGW-1:0]   r_res_mag;
    logic              r_res_neg;
    logic              r_done;
`ifdef CALC_MEM_EN
    logic [MAGW-1:0]   r_mem_mag;
    logic [BCDW-1:0]   r_mem_bcd;
    logic              r_mem_neg;
`endif

    logic                  w_digit_ok;
    logic [OPW-1:0]        w_ent_append;
    logic [ENTW-1:0]       w_ent_bcd_app;
    logic signed [OPW+1:0] w_sa, w_sb, w_sum;
    logic [OPW+1:0]        w_sum_abs;
    logic [MAGW-1:0]       w_acc_next;
    logic [OPW+1:0]        w_shift, w_trial;
    logic                  w_fit;
    logic [OPW-1:0]        w_quo_next;
    logic [MAGW-1:0]       w_calc_mag;
    logic                  w_calc_neg;
    logic                  w_last;
    logic [BCDW-1:0]       w_adj;

    assign w_digit_ok    = (bus.digit <= 4'd9);
    assign w_ent_append  = r_ent_mag * OPW'(10) + OPW'(bus.digit);
    assign w_ent_bcd_app = ENTW'({r_ent_bcd, bus.digit});

    assign w_sa      = r_a_neg ? -$signed({2'b00, r_a_mag}) : $signed({2'b00, r_a_mag});
    assign w_sb      = r_b_neg ? -$signed({2'b00, r_b_mag}) : $signed({2'b00, r_b_mag});
    assign w_sum     = (r_op == 2'd1) ? (w_sa - w_sb) : (w_sa + w_sb);
    assign w_sum_abs = w_sum[OPW+1] ? $unsigned(-w_sum) : $unsigned(w_sum);

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Restoring division step: remainder always stays below the divisor.
    assign w_shift    = {r_rem, r_quo[OPW-1]};
    assign w_trial    = w_shift - {2'b00, r_b_mag};
    assign w_fit      = ~w_trial[OPW+1];
    assign w_quo_next = {r_quo[OPW-2:0], w_fit};

    always_comb begin
        w_calc_mag = '0;
        case (r_op)
            2'd0, 2'd1: w_calc_mag = MAGW'(w_sum_abs);
            2'd2:       w_calc_mag = w_acc_next;
            default:    w_calc_mag = MAGW'(w_quo_next);
        endcase
    end

    assign w_calc_neg = (w_calc_mag != '0) && (r_op[1] ? (r_a_neg ^ r_b_neg) : w_sum[OPW+1]);
    assign w_last     = !r_op[1] || (r_cnt == CNTW'(OPW-1));

    generate
        for (genvar gi = 0; gi < 2*DIGITS; gi++) begin : g_dabble
            assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ? r_bcd[4*gi +: 4] + 4'd3
                                                                 : r_bcd[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_ENTER_A;
            r_op      <= '0;
            r_ent_mag <= '0;
            r_ent_bcd <= '0;
            r_ent_neg <= 1'b0;
            r_ent_cnt <= '0;
            r_a_mag   <= '0;
            r_a_neg   <= 1'b0;
            r_b_mag   <= '0;
            r_b_neg   <= 1'b0;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_res_mag <= '0;
            r_res_neg <= 1'b0;
            r_done    <= 1'b0;
`ifdef CALC_MEM_EN
            r_mem_mag <= '0;
            r_mem_bcd <= '0;
            r_mem_neg <= 1'b0;
`endif
        end else if (bus.clear) begin
            r_state   <= S_ENTER_A;
            r_op      <= '0;
            r_ent_mag <= '0;
            r_ent_bcd <= '0;
            r_ent_neg <= 1'b0;
            r_ent_cnt <= '0;
            r_a_mag   <= '0;
            r_a_neg   <= 1'b0;
            r_b_mag   <= '0;
            r_b_neg   <= 1'b0;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_res_mag <= '0;
            r_res_neg <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_ENTER_A, S_ENTER_B: begin
`ifdef CALC_MEM_EN
                    if (bus.mem_recall) begin
                        if (r_mem_mag <= MAXV) begin
                            r_ent_mag <= OPW'(r_mem_mag);
                            r_ent_bcd <= ENTW'(r_mem_bcd);
                            r_ent_neg <= r_mem_neg;
                            r_ent_cnt <= ECW'(DIGITS);
                        end else begin
                            r_state <= S_ERR;
                        end
                    end else
`endif
                    if (bus.equal_valid && r_state == S_ENTER_B) begin
                        r_b_mag  <= r_ent_mag;
                        r_b_neg  <= r_ent_neg;
                        r_cnt    <= '0;
                        r_mcand  <= MAGW'(r_a_mag);
                        r_mplier <= r_ent_mag;
                        r_acc    <= '0;
                        r_rem    <= '0;
                        r_quo    <= r_a_mag;
                        r_state  <= S_CALC;
                    end else if (bus.op_valid) begin
                        r_op <= bus.op;
                        if (r_state == S_ENTER_A) begin
                            r_a_mag   <= r_ent_mag;
                            r_a_neg   <= r_ent_neg;
                            r_ent_mag <= '0;
                            r_ent_bcd <= '0;
                            r_ent_neg <= 1'b0;
                            r_ent_cnt <= '0;
                            r_state   <= S_ENTER_B;
                        end
                    end else if (bus.neg_toggle) begin
                        r_ent_neg <= ~r_ent_neg;
                    end else if (bus.digit_valid && w_digit_ok && r_ent_cnt < ECW'(DIGITS)) begin
                        r_ent_mag <= w_ent_append;
                        r_ent_bcd <= w_ent_bcd_app;
                        r_ent_cnt <= r_ent_cnt + 1'b1;
                    end
                end
                S_CALC: begin
                    if (r_op == 2'd3 && r_b_mag == '0) begin
                        r_state <= S_ERR;
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_rem    <= w_fit ? w_trial[OPW:0] : w_shift[OPW:0];
                        r_quo    <= w_quo_next;
                        if (w_last) begin
                            r_res_mag <= w_calc_mag;
                            r_res_neg <= w_calc_neg;
                            r_bin     <= w_calc_mag;
                            r_bcd     <= '0;
                            r_cnt     <= '0;
                            r_state   <= S_CONVERT;
                        end
                    end
                end
                S_CONVERT: begin
                    r_bcd <= BCDW'({w_adj, r_bin[MAGW-1]});
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNTW'(MAGW-1)) begin
                        r_state <= S_SHOW;
                        r_done  <= 1'b1;
                    end
                end
                S_SHOW: begin
`ifdef CALC_MEM_EN
                    if (bus.mem_store) begin
                        r_mem_mag <= r_res_mag;
                        r_mem_bcd <= r_bcd;
                        r_mem_neg <= r_res_neg;
                    end else
`endif
                    if (bus.op_valid) begin
                        if (r_res_mag <= MAXV) begin
                            r_a_mag   <= OPW'(r_res_mag);
                            r_a_neg   <= r_res_neg;
                            r_op      <= bus.op;
                            r_ent_mag <= '0;
                            r_ent_bcd <= '0;
                            r_ent_neg <= 1'b0;
                            r_ent_cnt <= '0;
                            r_state   <= S_ENTER_B;
                        end else begin
                            r_state <= S_ERR;
                        end
                    end else if (bus.digit_valid && w_digit_ok) begin
                        r_ent_mag <= OPW'(bus.digit);
                        r_ent_bcd <= ENTW'(bus.digit);
                        r_ent_neg <= 1'b0;
                        r_ent_cnt <= ECW'(1);
                        r_state   <= S_ENTER_A;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.disp_bcd = '0;
        bus.disp_neg = 1'b0;
        if (r_state == S_ENTER_A || r_state == S_ENTER_B) begin
            bus.disp_bcd = BCDW'(r_ent_bcd);
            bus.disp_neg = r_ent_neg;
        end else if (r_state == S_SHOW) begin
            bus.disp_bcd = r_bcd;
            bus.disp_neg = r_res_neg;
        end
    end

    assign bus.busy  = (r_state == S_CALC) || (r_state == S_CONVERT);
    assign bus.done  = r_done;
    assign bus.error = (r_state == S_ERR);
    assign bus.state = r_state;
endmodule

// File: tb/tb_calc_engine.sv
// Scoreboard bench for calc_engine: directed cases plus random key sequences against an integer model.
module tb_calc_engine;
    localparam int DIGITS = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    calc_if #(.DIGITS(DIGITS)) bus ();
    calc_engine #(.DIGITS(DIGITS)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        logic [23:0] bcd;
        bit          neg;
        bit          is_err;
        int          lat;
        int          bsy;
        int          t0;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   bcount = 0;
    logic prev_err = 1'b0;

    // model of the calculator: phase 0 entering A, 1 entering B, 2 showing result, 3 error
    int ph = 0;
    int cur = 0;
    int cnt = 0;
    bit cur_neg = 0;
    int a_val = 0;
    int mop = 0;
    int res = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(int v);
        logic [23:0] r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    always @(negedge clk) begin
        if (bus.busy) begin
            bcount++;
        end else begin
            if (bus.done || (bus.error && !prev_err)) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("kind_err", bus.error, mon_e.is_err);
                    chk("disp_bcd", bus.disp_bcd, mon_e.bcd);
                    chk("disp_neg", bus.disp_neg, mon_e.neg);
                    chk("latency", cyc - mon_e.t0, mon_e.lat);
                    chk("busy_cycles", bcount, mon_e.bsy);
                    $display("txn err=%0b bcd=%06h neg=%0b lat=%0d busy=%0d",
                             bus.error, bus.disp_bcd, bus.disp_neg, cyc - mon_e.t0, bcount);
                end
            end
            bcount = 0;
        end
        prev_err = bus.error;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        ph = 0; cur = 0; cnt = 0; cur_neg = 0; a_val = 0; mop = 0; res = 0;
    endtask

    task automatic chk_entry();
        if (ph <= 1) begin
            chk("entry_bcd", bus.disp_bcd, to_bcd(cur));
            chk("entry_neg", bus.disp_neg, cur_neg);
        end
    endtask

    task automatic press_digit(int d);
        bus.digit = 4'(d);
        bus.digit_valid = 1'b1;
        step();
        bus.digit_valid = 1'b0;
        if (d <= 9) begin
            if (ph <= 1 && cnt < DIGITS) begin
                cur = cur * 10 + d;
                cnt++;
            end else if (ph == 2) begin
                ph = 0; cur = d; cnt = 1; cur_neg = 0;
            end
        end
        chk_entry();
    endtask

    task automatic press_neg();
        bus.neg_toggle = 1'b1;
        step();
        bus.neg_toggle = 1'b0;
        if (ph <= 1) cur_neg = !cur_neg;
        chk_entry();
    endtask

    task automatic press_op(int o);
        exp_t e;
        bus.op = 2'(o);
        bus.op_valid = 1'b1;
        if (ph == 2 && iabs(res) > 999) begin
            e.bcd = '0; e.neg = 0; e.is_err = 1; e.lat = 1; e.bsy = 0; e.t0 = cyc;
            sb_q.push_back(e);
        end
        step();
        bus.op_valid = 1'b0;
        if (ph == 0) begin
            a_val = cur_neg ? -cur : cur;
            mop = o; ph = 1; cur = 0; cnt = 0; cur_neg = 0;
        end else if (ph == 1) begin
            mop = o;
        end else if (ph == 2) begin
            if (iabs(res) <= 999) begin
                a_val = res; mop = o; ph = 1; cur = 0; cnt = 0; cur_neg = 0;
            end else begin
                ph = 3;
            end
        end
        chk_entry();
    endtask

    task automatic press_equal(bit wait_done);
        exp_t e;
        int   sb;
        bit   fired = 0;
        if (ph == 1) begin
            fired = 1;
            sb = cur_neg ? -cur : cur;
            e.t0 = cyc;
            if (mop == 3 && cur == 0) begin
                e.bcd = '0; e.neg = 0; e.is_err = 1; e.lat = 2; e.bsy = 1;
                ph = 3;
            end else begin
                case (mop)
                    0: res = a_val + sb;
                    1: res = a_val - sb;
                    2: res = a_val * sb;
                    default: res = a_val / sb;
                endcase
                e.bcd = to_bcd(iabs(res)); e.neg = (res < 0); e.is_err = 0;
                e.lat = (mop < 2) ? 22 : 31;
                e.bsy = (mop < 2) ? 21 : 30;
                ph = 2;
            end
            sb_q.push_back(e);
        end
        bus.equal_valid = 1'b1;
        step();
        bus.equal_valid = 1'b0;
        if (fired && wait_done) repeat (36) step();
    endtask

    task automatic press_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        model_reset();
    endtask

    task automatic enter_rand();
        int n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) press_neg();
            press_digit($urandom_range(0, 11));
        end
    endtask

    initial begin
        bus.digit_valid = 0; bus.digit = 0; bus.op_valid = 0; bus.op = 0;
        bus.neg_toggle = 0; bus.equal_valid = 0; bus.clear = 0;
`ifdef CALC_MEM_EN
        bus.mem_store = 0; bus.mem_recall = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bcd", bus.disp_bcd, 0);
        chk("rst_state", bus.state, 0);
        chk("rst_flags", {bus.disp_neg, bus.busy, bus.done, bus.error}, 0);
        reset_n = 1'b1;
        step();

        // add 123 + 456
        press_digit(1); press_digit(2); press_digit(3); press_op(0);
        press_digit(4); press_digit(5); press_digit(6); press_equal(1);
        chk("add_show", bus.disp_bcd, 24'h000579);

        // 999 * 999
        press_clear();
        press_digit(9); press_digit(9); press_digit(9); press_op(2);
        press_digit(9); press_digit(9); press_digit(9); press_equal(1);
        chk("mul_show", bus.disp_bcd, 24'h998001);

        // -12 / 5
        press_clear();
        press_digit(1); press_digit(2); press_neg(); press_op(3);
        press_digit(5); press_equal(1);
        chk("div_neg", {bus.disp_neg, bus.disp_bcd}, {1'b1, 24'h000002});

        // 7 / 0 then clear
        press_clear();
        press_digit(7); press_op(3); press_digit(0); press_equal(1);
        chk("div0_err", bus.error, 1);
        press_clear();
        chk("clr_state", bus.state, 0);
        chk("clr_err", bus.error, 0);

        // entry limit
        press_digit(1); press_digit(2); press_digit(3); press_digit(4);
        chk("entry_limit", bus.disp_bcd, 24'h000123);

        // chaining 5+3=8, +2 = 10
        press_clear();
        press_digit(5); press_op(0); press_digit(3); press_equal(1);
        press_op(0); press_digit(2); press_equal(1);
        chk("chain", bus.disp_bcd, 24'h000010);

        // chaining overflow: 999*2 = 1998, op -> error
        press_clear();
        press_digit(9); press_digit(9); press_digit(9); press_op(2);
        press_digit(2); press_equal(1);
        press_op(0);
        chk("chain_ovf", bus.error, 1);
        press_clear();

        // equal ignored while entering A
        press_digit(4); press_equal(1);
        repeat (3) step();
        chk("eqA_ignored", {bus.busy, bus.state}, 4'd0);

        // asynchronous reset during CALC
        press_clear();
        press_digit(9); press_op(2); press_digit(9); press_equal(0);
        repeat (3) step();
        sb_q.delete();
        reset_n = 1'b0;
        #1;
        chk("rst_mid_bcd", bus.disp_bcd, 0);
        chk("rst_mid_flags", {bus.disp_neg, bus.busy, bus.done, bus.error, bus.state}, 0);
        step();
        reset_n = 1'b1;
        model_reset();
        step();

        // clear during CONVERT
        press_digit(9); press_op(0); press_digit(1); press_equal(0);
        repeat (8) step();
        sb_q.delete();
        press_clear();
        chk("clr_mid", {bus.busy, bus.state}, 4'd0);
        repeat (30) step();

        // clear and equal together: clear wins
        press_digit(3); press_op(0); press_digit(4);
        bus.clear = 1'b1; bus.equal_valid = 1'b1;
        step();
        bus.clear = 1'b0; bus.equal_valid = 1'b0;
        model_reset();
        step();
        chk("clr_eq", {bus.busy, bus.state}, 4'd0);
        repeat (25) step();

        // random sequences
        for (int it = 0; it < 60; it++) begin
            if (ph == 3 || $urandom_range(0, 5) == 0) press_clear();
            if (ph == 2) begin
                if ($urandom_range(0, 1) == 1) press_digit($urandom_range(0, 9));
                else press_op($urandom_range(0, 3));
            end
            if (ph == 0) begin
                enter_rand();
                press_op($urandom_range(0, 3));
            end
            if (ph == 1) begin
                enter_rand();
                if ($urandom_range(0, 3) == 0) press_op($urandom_range(0, 3));
                press_equal(1);
            end
        end
        repeat (5) step();

        chk("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
